// File: rtl/alu_definitions.sv
// Shared execute-stage definitions: M-extension opcode, iteration count and
// the MDU control states.
package alu_definitions;

  // Encoding equals the RV32M funct3 field.
  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } mdu_op_t;

  localparam int MDU_STEPS = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } mdu_state_t;

  // Two's complement magnitude of a value flagged negative.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the iterative multiply/divide datapath.
// Multiply: {acc_hi, multiplier} shift-add, LSB of acc selects the add.
// Divide:   {remainder, dividend/quotient} restoring trial subtract.
module mdu_step
  import alu_definitions::*;
(
  input  logic        i_div,
  input  logic [63:0] i_acc,
  input  logic [31:0] i_opb,
  output logic [63:0] o_acc
);

  logic [32:0] w_sum;
  logic [32:0] w_shl;
  logic [32:0] w_trial;

  // Single-step next accumulator value for either operation.
  always_comb begin
    w_sum   = {1'b0, i_acc[63:32]} + {1'b0, i_opb};
    w_shl   = i_acc[63:31];
    w_trial = w_shl - {1'b0, i_opb};
    o_acc   = '0;
    if (i_div) begin
      // Borrow out of the trial subtract means the divisor did not fit.
      if (!w_trial[32]) o_acc = {w_trial[31:0], i_acc[30:0], 1'b1};
      else              o_acc = {w_shl[31:0],   i_acc[30:0], 1'b0};
    end else begin
      if (i_acc[0]) o_acc = {w_sum, i_acc[31:1]};
      else          o_acc = {1'b0, i_acc[63:1]};
    end
  end

endmodule

// File: rtl/mdu.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply or
// restoring divide on operand magnitudes, sign fix-up at the last step.
module mdu
  import alu_definitions::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_valid,
  output logic        start_ready,
  input  mdu_op_t     op,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic        flush,
  output logic        result_valid,
  input  logic        result_ready,
  output logic [31:0] result,
  output logic        busy
);

  mdu_state_t  r_state, w_state_nxt;
  mdu_op_t     r_op;
  logic [4:0]  r_cnt;
  logic [63:0] r_acc;
  logic [31:0] r_opb;
  logic        r_qneg, r_rneg;
  logic [31:0] r_result;
  logic        r_valid, r_busy;

  logic        w_accept, w_s1, w_s2, w_n1, w_n2;
  logic        w_div0, w_ovf, w_special;
  logic [31:0] w_special_res;
  logic [63:0] w_acc_nxt, w_prod;
  logic [31:0] w_quo, w_rem, w_final;

  assign start_ready  = (r_state == S_IDLE) && !flush;
  assign w_accept     = start_valid && start_ready;
  assign result_valid = r_valid;
  assign result       = r_result;
  assign busy         = r_busy;

  // Operand signedness, sign flags and special-case detection at accept.
  always_comb begin
    w_s1   = (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
    w_s2   = (op == MULH) || (op == DIV) || (op == REM);
    w_n1   = w_s1 && op1[31];
    w_n2   = w_s2 && op2[31];
    w_div0 = op[2] && (op2 == 32'd0);
    w_ovf  = ((op == DIV) || (op == REM)) &&
             (op1 == 32'h8000_0000) && (op2 == 32'hFFFF_FFFF);
    w_special     = w_div0 || w_ovf;
    w_special_res = '0;
    // op[1] separates remainder (REM/REMU) from quotient (DIV/DIVU).
    if (w_div0)     w_special_res = op[1] ? op1 : 32'hFFFF_FFFF;
    else if (w_ovf) w_special_res = op[1] ? 32'd0 : 32'h8000_0000;
  end

  mdu_step u_step (
    .i_div (r_op[2]),
    .i_acc (r_acc),
    .i_opb (r_opb),
    .o_acc (w_acc_nxt)
  );

  // Sign fix-up and result selection for the final iteration.
  always_comb begin
    w_prod  = r_qneg ? (~w_acc_nxt + 64'd1) : w_acc_nxt;
    w_quo   = mag32(w_acc_nxt[31:0], r_qneg);
    w_rem   = mag32(w_acc_nxt[63:32], r_rneg);
    w_final = '0;
    case (r_op)
      MUL:                 w_final = w_prod[31:0];
      MULH, MULHSU, MULHU: w_final = w_prod[63:32];
      DIV, DIVU:           w_final = w_quo;
      default:             w_final = w_rem;
    endcase
  end

  // Next-state logic; flush overrides every state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = w_special ? S_DONE : S_CALC;
      S_CALC: if (flush) w_state_nxt = S_IDLE;
              else if (r_cnt == 5'd0) w_state_nxt = S_DONE;
      S_DONE: if (flush || result_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= (w_state_nxt == S_DONE);
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  // Operand capture, iteration and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= MUL;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opb    <= '0;
      r_qneg   <= 1'b0;
      r_rneg   <= 1'b0;
      r_result <= '0;
    end else if (w_accept) begin
      r_op   <= op;
      r_cnt  <= 5'(MDU_STEPS - 1);
      r_acc  <= {32'd0, mag32(op1, w_n1)};
      r_opb  <= mag32(op2, w_n2);
      r_qneg <= w_n1 ^ w_n2;
      r_rneg <= w_n1;
      if (w_special) r_result <= w_special_res;
    end else if (r_state == S_CALC && !flush) begin
      r_acc <= w_acc_nxt;
      r_cnt <= r_cnt - 5'd1;
      if (r_cnt == 5'd0) r_result <= w_final;
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed table, randomized ops against a
// plain-arithmetic reference, flush/reset/backpressure sequences.
module tb_mdu;
  import alu_definitions::*;

  logic        clk, rst_n, start_valid, start_ready, flush;
  logic        result_valid, result_ready, busy;
  mdu_op_t     op;
  logic [31:0] op1, op2, result;

  int nvec = 0;
  int nerr = 0;

  mdu dut (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
    .op(op), .op1(op1), .op2(op2), .flush(flush), .result_valid(result_valid),
    .result_ready(result_ready), .result(result), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    mdu_op_t     o;
    logic [31:0] a, b, exp;
    int          lat, hold;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: RV32M semantics with 64-bit integer arithmetic.
  function automatic logic [31:0] ref_mdu(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    logic ovf;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = longint'({32'd0, a}); ub = longint'({32'd0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFF_FFFF; if (ovf) return a; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
      3'd6: begin if (b == 0) return a; if (ovf) return 32'd0; p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; return a % b; end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o[2] && b == 0) return 1;
    if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // One operation end to end: accept, wait, check, optional backpressure, retire.
  task automatic run_op(input string nm, input mdu_op_t o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat, input int hold);
    int n, rdy_hi, unstable;
    @(negedge clk);
    start_valid = 1'b1; op = o; op1 = a; op2 = b; result_ready = 1'b0;
    chk({nm, ".start_ready"}, {31'd0, start_ready}, 32'd1);
    @(posedge clk); #1;
    start_valid = 1'b0;
    n = 0; rdy_hi = 0;
    do begin
      @(negedge clk);
      n++;
      if (start_ready) rdy_hi++;
    end while (!result_valid && n < 100);
    chk({nm, ".latency"}, n, lat);
    chk({nm, ".result"}, result, exp);
    chk({nm, ".ready_low_while_busy"}, rdy_hi, 0);
    unstable = 0;
    for (int i = 0; i < hold; i++) begin
      start_valid = 1'b1; op = MUL; op1 = 32'd9; op2 = 32'd9;
      @(negedge clk);
      if (!result_valid || result !== exp || start_ready || !busy) unstable++;
    end
    if (hold > 0) chk({nm, ".held_stable"}, unstable, 0);
    start_valid = 1'b0;
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    @(negedge clk);
    chk({nm, ".idle_after_handshake"}, {29'd0, start_ready, result_valid, busy}, 32'b100);
  endtask

  vec_t tbl[$];

  initial begin
    int n, seen;
    logic [2:0] ro;
    logic [31:0] ra, rb;
    rst_n = 1'b1; start_valid = 1'b0; flush = 1'b0; result_ready = 1'b0;
    op = MUL; op1 = '0; op2 = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("reset.outputs", {28'd0, start_ready, result_valid, busy, 1'b0}, 32'b1000);
    chk("reset.result", result, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    tbl.push_back('{MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 5});
    tbl.push_back('{MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33, 0});
    tbl.push_back('{MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0});
    tbl.push_back('{MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 0});
    tbl.push_back('{DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33, 0});
    tbl.push_back('{REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33, 0});
    tbl.push_back('{DIVU,   32'd100,        32'd7,         32'h0000_000E, 33, 0});
    tbl.push_back('{REMU,   32'd100,        32'd7,         32'h0000_0002, 33, 1});
    tbl.push_back('{DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 1,  2});
    tbl.push_back('{REMU,   32'd5,          32'd0,         32'd5,         1,  0});
    tbl.push_back('{DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1,  0});
    tbl.push_back('{REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1,  0});
    foreach (tbl[i])
      run_op($sformatf("tbl%0d", i), tbl[i].o, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat, tbl[i].hold);

    // Randomized ops, with division by zero and overflow mixed in.
    for (int k = 0; k < 60; k++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom; rb = $urandom;
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      if ($urandom_range(0, 15) == 0) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
      run_op($sformatf("rnd%0d", k), mdu_op_t'(ro), ra, rb, ref_mdu(ro, ra, rb),
             ref_lat(ro, ra, rb), $urandom_range(0, 2));
    end

    // Flush in the 10th CALC cycle.
    @(negedge clk);
    start_valid = 1'b1; op = DIVU; op1 = 32'd1000; op2 = 32'd3;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush.idle_next", {29'd0, start_ready, result_valid, busy}, 32'b100);

    // Flush with a request in IDLE must not accept.
    flush = 1'b1; start_valid = 1'b1; op = MUL; op1 = 32'd2; op2 = 32'd2;
    #1;
    chk("flush.ready_blocked", {31'd0, start_ready}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; start_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (result_valid || busy) seen++;
    end
    chk("flush.no_result", seen, 0);
    run_op("flush.mul3x4", MUL, 32'd3, 32'd4, 32'd12, 33, 0);

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    start_valid = 1'b1; op = DIV; op1 = 32'hFFFF_0000; op2 = 32'd7;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (15) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid.outputs", {29'd0, start_ready, result_valid, busy}, 32'b100);
    chk("rst_mid.result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (result_valid || busy) n++;
    end
    chk("rst_mid.stays_idle", n, 0);
    run_op("rst_mid.recover", REMU, 32'd100, 32'd7, 32'd2, 33, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mdu.md
# mdu

Iterative RV32M multiply/divide unit; the sequential companion to the single-cycle integer ALU in the execute stage. Accepts one M-extension operation per valid/ready handshake, runs a 32-step shift-add multiply or restoring divide, and holds the 32-bit result until the pipeline takes it. Execute stalls on `start_ready`/`result_valid` while an M-op is in flight.

## Interface
- No parameters; datapath fixed at 32 bits.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `start_valid` input 1: operation request.
- `start_ready` output 1: request accepted when `start_valid && start_ready`.
- `op` input `mdu_op_t` (3): MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU; encoding equals RV32M funct3.
- `op1` input 32: rs1 value.
- `op2` input 32: rs2 value.
- `flush` input 1: synchronous abort of any in-flight operation.
- `result_valid` output 1: result available.
- `result_ready` input 1: consumer takes result when `result_valid && result_ready`.
- `result` output 32: final value; registered.
- `busy` output 1: high in CALC or DONE.

## Operation
- States: IDLE, CALC, DONE. `start_ready = (state==IDLE) && !flush`.
- IDLE: on accept, latch op, operand magnitudes, and sign flags, and load the step counter with 31.
  - Special division cases go directly to DONE.
  - Otherwise go to CALC.
- Signedness:
  - MULH and DIV/REM: both operands signed.
  - MULHSU: op1 signed, op2 unsigned.
  - MUL, MULHU, DIVU, REMU: unsigned datapath.
- CALC, multiply: one bit per cycle over a 64-bit product. Negate (64-bit two's complement) if operand signs differ. MUL returns [31:0]; MULH* return [63:32].
- CALC, divide: restoring, one quotient bit per cycle. Quotient negated if signs differ; remainder takes the dividend's sign.
- CALC: after the step with counter==0, register `result` and go to DONE.
- Special cases, bypassing CALC:
  - op2==0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give op1.
  - Signed DIV/REM of 0x80000000 by 0xFFFFFFFF: quotient 0x80000000, remainder 0.
- DONE: `result_valid`=1 and `result` stable until the handshake, then IDLE. No new accept in DONE.
- `flush` in any state: next state IDLE, `result_valid` drops the next cycle, and no result is produced. Flush with `start_valid` in IDLE: no accept.
- Reset values: state IDLE, `start_ready`=1, `result_valid`=0, `result`=0, `busy`=0. Reset mid-operation discards all state immediately.

## Timing
- Normal op: accept at edge N; CALC during cycles N+1..N+32; `result_valid` high after edge N+33.
- Special case: `result_valid` high after edge N+1.
- Result handshake at edge M: IDLE after M, `start_ready` high in cycle M+1. Maximum throughput is one op per 34 cycles.
- `result_ready` held low: unbounded wait, with outputs held.
- `start_ready` is combinational from state and `flush`. All other outputs are registered.

## Structure
- Add `mdu_op_t` to the existing `alu_definitions` package (3-bit enum, funct3 encoding), plus `MDU_STEPS = 32`.
- One sub-module, `mdu_step`: combinational single-iteration datapath (add/shift for multiply, trial subtract for divide). The top holds the FSM, counter, sign fix-up, and special-case detection.

## Test plan
- MUL 7 × 0xFFFFFFFD -> 0xFFFFFFEB; `result_valid` exactly 33 cycles after accept; `start_ready`=0 throughout.
- High-half multiplies:
  - MULH 0x80000000 × 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
- Division:
  - DIV −7/2 -> 0xFFFFFFFD.
  - REM −7/2 -> 0xFFFFFFFF.
  - DIVU 100/7 -> 0x0000000E.
  - REMU 100/7 -> 0x00000002.
- Special cases, each with `result_valid` one cycle after accept:
  - DIV 5/0 -> 0xFFFFFFFF.
  - REMU 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM 0x80000000/0xFFFFFFFF -> 0.
- Abort and reset:
  - `flush` in the 10th CALC cycle -> IDLE next cycle, no `result_valid`; a following MUL 3×4 -> 12.
  - `rst_n` low mid-divide -> all outputs at reset values within the same cycle.
- Backpressure: `result_ready` low for 5 cycles in DONE -> `result` and `result_valid` stable, `start_valid` ignored; after the handshake, `start_ready`=1 the next cycle.
